delay_credit_buffer: RTL and testbench

- Consumer stage directly downstream of the fixed-latency delay shift register.
- Absorbs the words the delay line produces (no backpressure there) into a FIFO and presents them on a valid/ready output.
- Credit-gates launches at the head of the delay line, so no word ever arrives at a full FIFO.
- Together with the delay line, forms a backpressure-safe fixed-latency path.

---
 rtl/delay_credit_buffer.sv | 79 +++++++
 tb/tb_delay_credit_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/delay_credit_buffer.sv
// delay_credit_buffer: credit-gated FIFO absorbing the tail of a fixed-latency delay line
// Optional feature macro: DCB_BYPASS_EN (combinational arr_* -> out_* path when empty).
// Ports:
//   clk, reset (async active-low)
//   launch_ready / launch       : credit gate at the head of the delay line
//   arr_valid / arr_data        : delay line tail, no backpressure
//   out_valid / out_data / out_ready : registered-head valid/ready output
//   level, credits              : FIFO occupancy and remaining launch credits
//   err_overrun, err_launch     : sticky protocol error flags
module delay_credit_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             launch_ready,
  input  logic             launch,
  input  logic             arr_valid,
  input  logic [WIDTH-1:0] arr_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    level,
  output logic [CW-1:0]    credits,
  output logic             err_overrun,
  output logic             err_launch
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [WIDTH-1:0] head_q, head_nxt;
  logic byp, full, pop, fifo_pop, push, take;
  logic [CW-1:0] level_nxt, credits_nxt;
  assign launch_ready = credits != '0;
  always_comb begin
`ifdef DCB_BYPASS_EN
    byp = (level == '0) & arr_valid;
`else
    byp = 1'b0;
`endif
    full = level == CW'(DEPTH);
    out_valid = byp | (level != '0);
    out_data = byp ? arr_data : head_q;
    pop = out_valid & out_ready;
    fifo_pop = pop & ~byp;
    // a bypassed word that is consumed the same cycle is never stored
    push = arr_valid & (~full | pop) & ~(byp & pop);
    take = launch & (credits != '0);
    rd_nxt = rd_ptr + AW'(fifo_pop);
    // next head comes from the arriving word when it lands straight at the head slot
    head_nxt = (push && wr_ptr == rd_nxt) ? arr_data : mem[rd_nxt];
    level_nxt = level + CW'(push) - CW'(fifo_pop);
    credits_nxt = credits + CW'(pop) - CW'(take);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      credits <= CW'(DEPTH);
      head_q <= '0;
      err_overrun <= 1'b0;
      err_launch <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_nxt;
      level <= level_nxt;
      credits <= credits_nxt;
      if (level_nxt != '0) head_q <= head_nxt;
      err_overrun <= err_overrun | (arr_valid & full & ~pop);
      err_launch <= err_launch | (launch & (credits == '0));
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= arr_data;
  a_no_credit_overflow: assert property (@(posedge clk) disable iff (!reset) !(pop && credits == CW'(DEPTH)));
  a_credit_range: assert property (@(posedge clk) disable iff (!reset) credits <= CW'(DEPTH) && level <= CW'(DEPTH));
endmodule

// File: tb/tb_delay_credit_buffer.sv
// tb_delay_credit_buffer: randomized + directed check of delay_credit_buffer against a queue model
module tb_delay_credit_buffer;
  logic clk, reset, launch_ready, launch, arr_valid, out_valid, out_ready, err_overrun, err_launch;
  logic [31:0] arr_data, out_data;
  logic [3:0] level, credits;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  int mcr = 8;
  logic mov = 0, mla = 0;
  logic [31:0] last = 0;
  logic [3:0] dl_v = 0;
  logic [31:0] dl_d [4];

  delay_credit_buffer #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .launch_ready(launch_ready), .launch(launch),
    .arr_valid(arr_valid), .arr_data(arr_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .level(level), .credits(credits),
    .err_overrun(err_overrun), .err_launch(err_launch)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task model_clear();
    q.delete();
    mcr = 8;
    mov = 0;
    mla = 0;
    last = 0;
    dl_v = 0;
  endtask

  // one clock cycle: entered and left at posedge+1; l enters the 4-deep delay line,
  // xv/xd force an extra arrival at the tail
  task cyc(input logic l, input logic [31:0] ld, input logic rdy, input logic xv, input logic [31:0] xd);
    logic av, ev, pop, byp;
    logic [31:0] ad, ed;
    av = dl_v[3] | xv;
    ad = xv ? xd : dl_d[3];
    launch = l;
    arr_valid = av;
    arr_data = ad;
    out_ready = rdy;
    ev = q.size() != 0;
    ed = ev ? q[0] : last;
    byp = 0;
`ifdef DCB_BYPASS_EN
    if (!ev && av) begin
      byp = 1;
      ev = 1;
      ed = ad;
    end
`endif
    @(negedge clk);
    chk("launch_ready", {31'd0, launch_ready}, {31'd0, mcr != 0});
    chk("credits", {28'd0, credits}, mcr);
    chk("level", {28'd0, level}, q.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("out_data", out_data, ed);
    chk("err_overrun", {31'd0, err_overrun}, {31'd0, mov});
    chk("err_launch", {31'd0, err_launch}, {31'd0, mla});
    pop = ev & rdy;
    if (q.size() != 0) last = q[0];
    if (pop && !byp) void'(q.pop_front());
    if (av && !(byp && pop)) begin
      if (q.size() < 8) q.push_back(ad);
      else mov = 1;
    end
    if (l && mcr == 0) mla = 1;
    mcr = mcr + int'(pop) - int'(l && mcr > 0);
    dl_v = {dl_v[2:0], l};
    dl_d[3] = dl_d[2];
    dl_d[2] = dl_d[1];
    dl_d[1] = dl_d[0];
    dl_d[0] = ld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0;
    launch = 0;
    arr_valid = 0;
    arr_data = 0;
    out_ready = 0;
    for (int i = 0; i < 4; i++) dl_d[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_launch_ready", {31'd0, launch_ready}, 1);
    chk("rst_credits", {28'd0, credits}, 8);
    chk("rst_level", {28'd0, level}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_errs", {30'd0, err_overrun, err_launch}, 0);
    reset = 1;
    // fill with 0xA0..0xA7 through the delay line, no consumer
    for (int i = 0; i < 8; i++) cyc(1, 32'hA0 + i, 0, 0, 0);
    chk("fill_credits0", {28'd0, credits}, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    chk("fill_level8", {28'd0, level}, 8);
    // drain, then a second pass to wrap the pointers
    repeat (9) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 32'hB0 + i, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 1, 0, 0);
    chk("wrap_credits8", {28'd0, credits}, 8);
    // full FIFO then push+pop, push without pop, forced launch at zero credits
    for (int i = 0; i < 8; i++) cyc(1, 32'hC0 + i, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'hD0);
    chk("pushpop_no_overrun", {31'd0, err_overrun}, 0);
    cyc(0, 0, 0, 1, 32'hD1);
    cyc(0, 0, 0, 0, 0);
    chk("overrun_sticky", {31'd0, err_overrun}, 1);
    cyc(1, 32'hE0, 0, 0, 0);
    cyc(1, 32'hE1, 0, 0, 0);
    chk("err_launch_set", {31'd0, err_launch}, 1);
    chk("credits_no_underflow", {28'd0, credits}, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'hF0 + i, 0, 0, 0);
    chk("pre_rst_level", {28'd0, level}, 5);
    chk("pre_rst_credits", {28'd0, credits}, 0);
    // asynchronous reset away from any clock edge
    #1;
    reset = 0;
    launch = 0;
    arr_valid = 0;
    out_ready = 0;
    #1;
    chk("async_launch_ready", {31'd0, launch_ready}, 1);
    chk("async_credits", {28'd0, credits}, 8);
    chk("async_level", {28'd0, level}, 0);
    chk("async_out_valid", {31'd0, out_valid}, 0);
    chk("async_out_data", out_data, 0);
    chk("async_errs", {30'd0, err_overrun, err_launch}, 0);
    model_clear();
    reset = 1;
    @(posedge clk);
    #1;
    // single word into an empty FIFO with the consumer ready
    cyc(1, 32'h5A, 1, 0, 0);
    repeat (6) cyc(0, 0, 1, 0, 0);
    // randomized honest traffic
    for (int i = 0; i < 1500; i++) begin
      logic l, r;
      l = (mcr != 0) && ($urandom_range(0, 3) != 0);
      r = (i % 300 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cyc(l, $urandom, r, 0, 0);
    end
    for (int i = 0; i < 40 && (q.size() != 0 || dl_v != 0); i++) cyc(0, 0, 1, 0, 0);
    chk("drain_level", {28'd0, level}, 0);
    chk("drain_credits", {28'd0, credits}, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
